// File: rtl/svnseg_source_arbiter.sv
// rtl/svnseg_source_arbiter.sv - round-robin owner of the 4-digit seven-segment display
// Grants one requester at a time, holds it for HOLD_CYCLES, then rotates.
module svnseg_source_arbiter #(
   parameter int          NUM_SRC     = 4,
   parameter logic [23:0] HOLD_CYCLES = 24'd1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     req,
   input  logic [16*NUM_SRC-1:0]  value,
   output logic [NUM_SRC-1:0]     grant,
   output logic [1:0]             active_src,
   output logic                   blank,
   output logic [3:0]             num3,
   output logic [3:0]             num2,
   output logic [3:0]             num1,
   output logic [3:0]             num0
);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

   state_t             state_q, state_d;
   logic [23:0]        timer_q, timer_d;
   logic [1:0]         last_q, last_d;
   logic [1:0]         active_d;
   logic [NUM_SRC-1:0] grant_d;
   logic               blank_d;
   logic [15:0]        disp_q, disp_d;

   logic [3:0]         cand4;
   logic [3:0]         onehot4;
   logic [63:0]        value4;
   logic [1:0]         scan_idx;
   logic [1:0]         pick_idx;
   logic               pick_found;
   logic               own_req;
   logic               decide;
   logic               take;

   // Candidates exclude the current owner, so an open grant only moves to another source.
   assign cand4   = 4'(req & ~grant);
   assign value4  = 64'(value);
   assign own_req = |(req & grant);
   assign onehot4 = 4'b0001 << pick_idx;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      scan_idx   = 2'd0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         scan_idx = 2'((int'(last_q) + k) % NUM_SRC);
         if (!pick_found && cand4[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Hold expiry is evaluated like OPEN so a grant lasts exactly HOLD_CYCLES when contended.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      last_d   = last_q;
      active_d = active_src;
      grant_d  = grant;
      blank_d  = blank;
      decide   = (state_q == S_OPEN) || (state_q == S_HOLD && timer_q == 24'd0);
      take     = pick_found && (state_q == S_IDLE || decide);
      if (take) begin
         state_d  = S_HOLD;
         timer_d  = HOLD_CYCLES - 24'd1;
         last_d   = pick_idx;
         active_d = pick_idx;
         grant_d  = onehot4[NUM_SRC-1:0];
         blank_d  = 1'b0;
      end else if (decide && !own_req) begin
         state_d  = S_IDLE;
         timer_d  = 24'd0;
         active_d = 2'd0;
         grant_d  = '0;
         blank_d  = 1'b1;
      end else if (decide) begin
         state_d = S_OPEN;
      end else if (state_q == S_HOLD) begin
         timer_d = timer_q - 24'd1;
      end
      disp_d = (state_d == S_IDLE || blank) ? 16'h0000 : value4[{active_src, 4'b0000} +: 16];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= 24'd0;
         last_q     <= 2'(NUM_SRC - 1);
         active_src <= 2'd0;
         grant      <= '0;
         blank      <= 1'b1;
         disp_q     <= 16'h0000;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         last_q     <= last_d;
         active_src <= active_d;
         grant      <= grant_d;
         blank      <= blank_d;
         disp_q     <= disp_d;
      end
   end

   assign num3 = disp_q[15:12];
   assign num2 = disp_q[11:8];
   assign num1 = disp_q[7:4];
   assign num0 = disp_q[3:0];

endmodule
